// File: rtl/sm_restorer.sv
// sm_restorer: bit-serial inverse of the magnitude/borrow subtractor.
// Rebuilds A from B, D=|A-B| and the borrow flag: A = B + D (neg=0) or
// A = B - D (neg=1). One result bit is produced per cycle, LSB first.
module sm_restorer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         start,
  input  logic [W-1:0] B,
  input  logic [W-1:0] D,
  input  logic         neg,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         done,
  output logic         rdy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [W-1:0]  rb;
  logic [W-1:0]  rd;
  logic [W-1:0]  acc;
  logic          rneg;
  logic          carry;
  logic [CW-1:0] cnt;

  logic addend;
  logic sum_bit;
  logic carry_next;

  // One full-adder slice; subtraction inverts D and injects the +1 through the initial carry
  always_comb begin
    addend     = rd[0] ^ rneg;
    sum_bit    = rb[0] ^ addend ^ carry;
    carry_next = (rb[0] & addend) | (rb[0] & carry) | (addend & carry);
  end

  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; unknown encodings fall back to idle
  always_comb begin
    next_state = state;
    rdy        = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (start) begin
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == LAST) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting and result/overflow commit on the final bit
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rb     <= '0;
      rd     <= '0;
      acc    <= '0;
      rneg   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          rb    <= B;
          rd    <= D;
          rneg  <= neg;
          carry <= neg;
          cnt   <= '0;
        end
      end else if (state == S_SHIFT) begin
        rb    <= rb >> 1;
        rd    <= rd >> 1;
        acc   <= {sum_bit, acc[W-1:1]};
        carry <= carry_next;
        if (cnt == LAST) begin
          result <= {sum_bit, acc[W-1:1]};
          ovf    <= rneg ? ~carry_next : carry_next;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_restorer.sv
// Directed and sampled round-trip bench for sm_restorer (W=8).
module tb_sm_restorer;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic [7:0] B;
  logic [7:0] D;
  logic       neg;
  logic [7:0] result;
  logic       ovf;
  logic       done;
  logic       rdy;

  int checks;
  int failures;

  sm_restorer #(.W(8)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .start  (start),
    .B      (B),
    .D      (D),
    .neg    (neg),
    .result (result),
    .ovf    (ovf),
    .done   (done),
    .rdy    (rdy)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Runs one operation from an idle DUT and checks latency, result, ovf and the done pulse
  task automatic applyStimulus(input string tag, input logic [7:0] b, input logic [7:0] d,
                               input logic n, input logic [7:0] exp_a, input logic exp_ovf);
    int k;
    int waited;
    bit seen;
    waited = 0;
    @(negedge clk);
    while (!rdy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy) begin
      checkOutput({tag, "_rdy_timeout"}, 0, 1);
      return;
    end
    B = b;
    D = d;
    neg = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    B = ~b;
    D = ~d;
    neg = ~n;
    seen = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 0, 1);
      return;
    end
    checkOutput({tag, "_latency"}, k, 8);
    checkOutput({tag, "_result"}, result, exp_a);
    checkOutput({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_once"}, done, 0);
    checkOutput({tag, "_rdy_back"}, rdy, 1);
    checkOutput({tag, "_result_hold"}, result, exp_a);
  endtask

  logic [8:0] exp_q[$];
  logic [8:0] popped;
  logic [7:0] ra;
  logic [7:0] rbv;
  logic [8:0] sum9;
  int last_done;
  int ndone;

  initial begin
    checks = 0;
    failures = 0;
    rst_b = 1'b0;
    start = 1'b0;
    B = '0;
    D = '0;
    neg = 1'b0;
    #12;
    checkOutput("reset_result", result, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rdy", rdy, 1);
    @(negedge clk);
    rst_b = 1'b1;

    $display("[TB] directed vectors");
    applyStimulus("add_20_15", 8'd20, 8'd15, 1'b0, 8'd35, 1'b0);
    applyStimulus("sub_20_15", 8'd20, 8'd15, 1'b1, 8'd5, 1'b0);
    applyStimulus("sub_0_0", 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    applyStimulus("add_200_100", 8'd200, 8'd100, 1'b0, 8'd44, 1'b1);
    applyStimulus("sub_5_10", 8'd5, 8'd10, 1'b1, 8'd251, 1'b1);
    applyStimulus("sub_99_0", 8'd99, 8'd0, 1'b1, 8'd99, 1'b0);
    applyStimulus("add_255_1", 8'd255, 8'd1, 1'b0, 8'd0, 1'b1);
    applyStimulus("add_128_127", 8'd128, 8'd127, 1'b0, 8'd255, 1'b0);

    $display("[TB] start held high, inputs changing every cycle");
    exp_q.delete();
    last_done = -1;
    ndone = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream_unexpected_done", 1, 0);
        end else begin
          popped = exp_q.pop_front();
          checkOutput("stream_result", result, popped[7:0]);
          checkOutput("stream_ovf", ovf, popped[8]);
        end
        if (last_done >= 0) begin
          checkOutput("stream_interval", cyc - last_done, 10);
        end
        last_done = cyc;
        ndone++;
      end
      B = 8'($urandom_range(0, 255));
      D = 8'($urandom_range(0, 255));
      neg = 1'($urandom_range(0, 1));
      start = (cyc < 45);
      if (rdy && start) begin
        if (neg) begin
          exp_q.push_back({(B < D), 8'(B - D)});
        end else begin
          sum9 = {1'b0, B} + {1'b0, D};
          exp_q.push_back(sum9);
        end
      end
    end
    start = 1'b0;
    checkOutput("stream_queue_empty", exp_q.size(), 0);
    checkOutput("stream_done_count", ndone, 5);

    $display("[TB] reset during an operation");
    applyStimulus("pre_reset", 8'd100, 8'd50, 1'b0, 8'd150, 1'b0);
    @(negedge clk);
    B = 8'd77;
    D = 8'd3;
    neg = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("midreset_rdy", rdy, 1);
    checkOutput("midreset_done", done, 0);
    checkOutput("midreset_result", result, 0);
    checkOutput("midreset_ovf", ovf, 0);
    @(negedge clk);
    rst_b = 1'b1;
    applyStimulus("post_reset", 8'd9, 8'd4, 1'b1, 8'd5, 1'b0);

    $display("[TB] round trip, corners and random pairs");
    for (int i = 0; i < 136; i++) begin
      if (i < 36) begin
        case (i % 6)
          0: ra = 8'd0;  1: ra = 8'd1;   2: ra = 8'd127;
          3: ra = 8'd128; 4: ra = 8'd254; default: ra = 8'd255;
        endcase
        case (i / 6)
          0: rbv = 8'd0;  1: rbv = 8'd1;   2: rbv = 8'd127;
          3: rbv = 8'd128; 4: rbv = 8'd254; default: rbv = 8'd255;
        endcase
      end else begin
        ra = 8'($urandom_range(0, 255));
        rbv = 8'($urandom_range(0, 255));
      end
      applyStimulus("roundtrip", rbv, (ra >= rbv) ? 8'(ra - rbv) : 8'(rbv - ra),
                    (ra < rbv), ra, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
